// File: rtl/chunked_argmax_sequencer.sv
// rtl/chunked_argmax_sequencer.sv - running signed max/argmax over NUM_CHUNKS 16-element chunks

// Combinational 16-input signed argmax; equal pairs resolve to the higher index.
module parallel_argmax_signed_16_inputs #(
    parameter int WIDTH = 8
) (
    input  logic [15:0][WIDTH-1:0] data_i,
    output logic signed [WIDTH-1:0] max_o,
    output logic [3:0]              idx_o
);

    // Heap-ordered comparison tree: leaves 15..30 hold lanes 0..15 left to right,
    // so choosing the right child on equality keeps the higher lane index.
    always_comb begin : tree
        logic signed [WIDTH-1:0] node_val [31];
        logic [3:0]              node_idx [31];
        for (int i = 0; i < 31; i++) begin
            node_val[i] = '0;
            node_idx[i] = '0;
        end
        for (int k = 0; k < 16; k++) begin
            node_val[15+k] = $signed(data_i[k]);
            node_idx[15+k] = 4'(k);
        end
        for (int i = 14; i >= 0; i--) begin
            if (node_val[2*i+2] >= node_val[2*i+1]) begin
                node_val[i] = node_val[2*i+2];
                node_idx[i] = node_idx[2*i+2];
            end else begin
                node_val[i] = node_val[2*i+1];
                node_idx[i] = node_idx[2*i+1];
            end
        end
        max_o = node_val[0];
        idx_o = node_idx[0];
    end

endmodule

module chunked_argmax_sequencer #(
    parameter int WIDTH      = 8,
    parameter int NUM_CHUNKS = 4,
    localparam int IDX_WIDTH = ($clog2(16*NUM_CHUNKS) < 4) ? 4 : $clog2(16*NUM_CHUNKS),
    localparam int CNT_WIDTH = $clog2(NUM_CHUNKS+1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [15:0][WIDTH-1:0]      in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH-1:0]     out_max,
    output logic [IDX_WIDTH-1:0]        out_argmax,
    output logic [CNT_WIDTH-1:0]        chunk_count
);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t                  state_q;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] out_max_q;
    logic [IDX_WIDTH-1:0]    out_argmax_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic signed [WIDTH-1:0] run_max_q, run_max_d;
    logic [IDX_WIDTH-1:0]    run_idx_q, run_idx_d;

    logic signed [WIDTH-1:0] chunk_max;
    logic [3:0]              chunk_idx;
    logic [IDX_WIDTH-1:0]    glob_idx;
    logic                    in_xfer;
    logic                    first_chunk;
    logic                    last_chunk;

    parallel_argmax_signed_16_inputs #(.WIDTH(WIDTH)) u_chunk_argmax (
        .data_i (in_data),
        .max_o  (chunk_max),
        .idx_o  (chunk_idx)
    );

    // Only a pending, unaccepted result stalls the input side.
    assign in_ready    = !rst && (!out_valid_q || out_ready);
    assign in_xfer     = in_valid && in_ready;
    assign first_chunk = (cnt_q == '0);
    assign last_chunk  = (cnt_q == CNT_WIDTH'(NUM_CHUNKS-1));
    // cnt_q never exceeds NUM_CHUNKS-1, so {chunk, lane} always fits IDX_WIDTH.
    assign glob_idx    = IDX_WIDTH'({cnt_q, chunk_idx});

    assign out_valid   = out_valid_q;
    assign out_max     = out_max_q;
    assign out_argmax  = out_argmax_q;
    assign chunk_count = cnt_q;

    // Merge the current chunk into the running max; >= lets later chunks win ties.
    always_comb begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        if (first_chunk) begin
            run_max_d = chunk_max;
            run_idx_d = IDX_WIDTH'(chunk_idx);
        end else if (chunk_max >= run_max_q) begin
            run_max_d = chunk_max;
            run_idx_d = glob_idx;
        end
    end

    // Sequencer FSM: output handoff first, then a same-cycle chunk may start the next vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            out_valid_q  <= 1'b0;
            out_max_q    <= '0;
            out_argmax_q <= '0;
            cnt_q        <= '0;
            run_max_q    <= '0;
            run_idx_q    <= '0;
        end else begin
            if (state_q == DONE && out_ready) begin
                state_q     <= ACCUM;
                out_valid_q <= 1'b0;
            end
            if (in_xfer) begin
                run_max_q <= run_max_d;
                run_idx_q <= run_idx_d;
                if (last_chunk) begin
                    state_q      <= DONE;
                    out_valid_q  <= 1'b1;
                    out_max_q    <= run_max_d;
                    out_argmax_q <= run_idx_d;
                    cnt_q        <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_argmax_sequencer.sv
// tb/tb_chunked_argmax_sequencer.sv - self-checking bench for chunked_argmax_sequencer
module tb_chunked_argmax_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // NUM_CHUNKS=4 instance
    logic              in_valid4 = 1'b0;
    logic              in_ready4;
    logic [15:0][7:0]  in_data4 = '0;
    logic              out_valid4;
    logic              out_ready4 = 1'b0;
    logic signed [7:0] out_max4;
    logic [5:0]        out_argmax4;
    logic [2:0]        chunk_count4;

    // NUM_CHUNKS=1 instance
    logic              in_valid1 = 1'b0;
    logic              in_ready1;
    logic [15:0][7:0]  in_data1 = '0;
    logic              out_valid1;
    logic              out_ready1 = 1'b0;
    logic signed [7:0] out_max1;
    logic [3:0]        out_argmax1;
    logic [0:0]        chunk_count1;

    chunked_argmax_sequencer #(.WIDTH(8), .NUM_CHUNKS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_max(out_max4),
        .out_argmax(out_argmax4), .chunk_count(chunk_count4)
    );

    chunked_argmax_sequencer #(.WIDTH(8), .NUM_CHUNKS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_max(out_max1),
        .out_argmax(out_argmax1), .chunk_count(chunk_count1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic signed [7:0] vecs [8][64];

    int q_max4[$], q_idx4[$], q_cyc4[$];
    int q_max1[$], q_idx1[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record each output handshake just before the edge that completes it.
    always @(negedge clk) begin
        if (!rst && out_valid4 && out_ready4) begin
            q_max4.push_back(int'(out_max4));
            q_idx4.push_back(int'(out_argmax4));
            q_cyc4.push_back(cyc);
        end
        if (!rst && out_valid1 && out_ready1) begin
            q_max1.push_back(int'(out_max1));
            q_idx1.push_back(int'(out_argmax1));
        end
    end

    // Reference: scan the whole vector; >= keeps the last (highest) index of the max.
    function automatic void ref_model(input int v, input int n, output int mx, output int ix);
        mx = -1000;
        ix = -1;
        for (int i = 0; i < n; i++) begin
            if (int'(vecs[v][i]) >= mx) begin
                mx = int'(vecs[v][i]);
                ix = i;
            end
        end
    endfunction

    task automatic push_chunk4(input logic [15:0][7:0] d);
        bit ok = 1'b0;
        in_valid4 = 1'b1;
        in_data4  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready4) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push4_timeout: in_ready4 stayed %0b, required 1", in_ready4);
        end
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
    endtask

    task automatic push_vec4(input int v, input int c0, input int c1, input bit gaps);
        logic [15:0][7:0] d;
        for (int c = c0; c <= c1; c++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            for (int k = 0; k < 16; k++) d[k] = vecs[v][c*16+k];
            push_chunk4(d);
        end
    endtask

    task automatic push_chunk1(input int v);
        logic [15:0][7:0] d;
        bit ok = 1'b0;
        for (int k = 0; k < 16; k++) d[k] = vecs[v][k];
        in_valid1 = 1'b1;
        in_data1  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push1_timeout: in_ready1 stayed %0b, required 1", in_ready1);
        end
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_results4(input int n);
        for (int t = 0; t < 200 && q_max4.size() < n; t++) @(posedge clk);
        #1;
    endtask

    task automatic clear_q4();
        q_max4.delete();
        q_idx4.delete();
        q_cyc4.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready4 !== 1'b0 || in_ready1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready_low: got %0b/%0b, required 0/0", in_ready4, in_ready1);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready4 !== 1'b0 || out_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: in_ready=%0b out_valid=%0b, required 0/0", in_ready4, out_valid4);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready4 !== 1'b1 || in_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %0b/%0b, required 1/1", in_ready4, in_ready1);
        end
        total++;
        if (out_valid4 !== 1'b0 || chunk_count4 !== 3'd0 || out_max4 !== 8'sd0 || out_argmax4 !== 6'd0) begin
            bad++;
            $display("FAIL reset_state: valid=%0b cnt=%0d max=%0d idx=%0d, required 0/0/0/0",
                     out_valid4, chunk_count4, out_max4, out_argmax4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_peak();
        clear_q4();
        out_ready4 = 1'b1;
        for (int i = 0; i < 64; i++) vecs[0][i] = -8'sd1;
        vecs[0][37] = 8'sd100;
        push_vec4(0, 0, 3, 1'b0);
        total++;
        if (out_valid4 !== 1'b1 || out_max4 !== 8'sd100 || out_argmax4 !== 6'd37) begin
            bad++;
            $display("FAIL single_peak: valid=%0b max=%0d idx=%0d, required 1/100/37",
                     out_valid4, out_max4, out_argmax4);
        end
        total++;
        if (chunk_count4 !== 3'd0) begin
            bad++;
            $display("FAIL single_peak_count: got %0d, required 0", chunk_count4);
        end
        wait_results4(1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_ties_and_sign();
        clear_q4();
        out_ready4 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            vecs[0][i] = -8'sd128;
            vecs[1][i] = -8'sd128;
        end
        vecs[0][3]  = 8'sd127;
        vecs[0][50] = 8'sd127;
        vecs[1][0]  = -8'sd1;
        push_vec4(0, 0, 3, 1'b0);
        push_vec4(1, 0, 3, 1'b0);
        wait_results4(2);
        total++;
        if (q_max4.size() != 2) begin
            bad++;
            $display("FAIL ties_count: got %0d results, required 2", q_max4.size());
        end else begin
            total++;
            if (q_max4[0] != 127 || q_idx4[0] != 50) begin
                bad++;
                $display("FAIL tie_high_index: max=%0d idx=%0d, required 127/50", q_max4[0], q_idx4[0]);
            end
            total++;
            if (q_max4[1] != -1 || q_idx4[1] != 0) begin
                bad++;
                $display("FAIL signed_compare: max=%0d idx=%0d, required -1/0", q_max4[1], q_idx4[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int mx0, ix0, mx1, ix1;
        logic [15:0][7:0] d;
        clear_q4();
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < 64; i++) vecs[v][i] = 8'($urandom_range(0, 255));
        ref_model(0, 64, mx0, ix0);
        ref_model(1, 64, mx1, ix1);
        out_ready4 = 1'b0;
        push_vec4(0, 0, 3, 1'b0);
        for (int k = 0; k < 16; k++) d[k] = vecs[1][k];
        in_valid4 = 1'b1;
        in_data4  = d;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            total++;
            if (in_ready4 !== 1'b0 || out_valid4 !== 1'b1 || int'(out_max4) != mx0 ||
                int'(out_argmax4) != ix0 || chunk_count4 !== 3'd0) begin
                bad++;
                $display("FAIL backpressure_hold: rdy=%0b valid=%0b max=%0d idx=%0d cnt=%0d, required 0/1/%0d/%0d/0",
                         in_ready4, out_valid4, out_max4, out_argmax4, chunk_count4, mx0, ix0);
            end
        end
        @(posedge clk);
        #1;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        total++;
        if (chunk_count4 !== 3'd1 || out_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL concurrent_xfer: cnt=%0d valid=%0b, required 1/0", chunk_count4, out_valid4);
        end
        push_vec4(1, 1, 3, 1'b0);
        wait_results4(2);
        total++;
        if (q_max4.size() != 2 || q_max4[0] != mx0 || q_idx4[0] != ix0 ||
            q_max4[1] != mx1 || q_idx4[1] != ix1) begin
            bad++;
            $display("FAIL backpressure_results: n=%0d, required 2 with %0d/%0d then %0d/%0d",
                     q_max4.size(), mx0, ix0, mx1, ix1);
        end
    endtask

    task automatic test_back_to_back();
        int mx[6], ix[6];
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 64; i++)
                vecs[v][i] = (v % 2 == 0) ? 8'($urandom_range(0, 7) - 4) : 8'($urandom_range(0, 255));
            ref_model(v, 64, mx[v], ix[v]);
        end
        out_ready4 = 1'b1;
        for (int run = 0; run < 2; run++) begin
            clear_q4();
            for (int v = 0; v < 6; v++) push_vec4(v, 0, 3, run == 1);
            wait_results4(6);
            total++;
            if (q_max4.size() != 6) begin
                bad++;
                $display("FAIL b2b_count run%0d: got %0d, required 6", run, q_max4.size());
            end else begin
                for (int v = 0; v < 6; v++) begin
                    total++;
                    if (q_max4[v] != mx[v] || q_idx4[v] != ix[v]) begin
                        bad++;
                        $display("FAIL b2b_result run%0d vec%0d: max=%0d idx=%0d, required %0d/%0d",
                                 run, v, q_max4[v], q_idx4[v], mx[v], ix[v]);
                    end
                    if (run == 0 && v > 0) begin
                        total++;
                        if (q_cyc4[v] - q_cyc4[v-1] != 4) begin
                            bad++;
                            $display("FAIL b2b_spacing vec%0d: got %0d cycles, required 4",
                                     v, q_cyc4[v] - q_cyc4[v-1]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_vector();
        clear_q4();
        out_ready4 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            vecs[0][i] = 8'($urandom_range(0, 217) - 128);
            vecs[1][i] = 8'($urandom_range(0, 147) - 128);
        end
        vecs[0][10] = 8'sd90;
        vecs[1][63] = 8'sd20;
        push_vec4(0, 0, 1, 1'b0);
        total++;
        if (chunk_count4 !== 3'd2) begin
            bad++;
            $display("FAIL mid_count: got %0d, required 2", chunk_count4);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready4 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_ready: got %0b, required 0", in_ready4);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (chunk_count4 !== 3'd0 || out_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_state: cnt=%0d valid=%0b, required 0/0", chunk_count4, out_valid4);
        end
        push_vec4(1, 0, 3, 1'b1);
        wait_results4(1);
        total++;
        if (q_max4.size() != 1 || q_max4[0] != 20 || q_idx4[0] != 63) begin
            bad++;
            $display("FAIL after_reset_vector: n=%0d max=%0d idx=%0d, required 1/20/63",
                     q_max4.size(), q_max4.size() > 0 ? q_max4[0] : 0, q_idx4.size() > 0 ? q_idx4[0] : 0);
        end
    endtask

    task automatic test_single_chunk();
        int mx[8], ix[8];
        q_max1.delete();
        q_idx1.delete();
        out_ready1 = 1'b1;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 16; i++)
                vecs[v][i] = (v < 4) ? 8'($urandom_range(0, 5) - 3) : 8'($urandom_range(0, 255));
            ref_model(v, 16, mx[v], ix[v]);
        end
        for (int v = 0; v < 8; v++) push_chunk1(v);
        for (int t = 0; t < 50 && q_max1.size() < 8; t++) @(posedge clk);
        total++;
        if (q_max1.size() != 8) begin
            bad++;
            $display("FAIL nc1_count: got %0d, required 8", q_max1.size());
        end else begin
            for (int v = 0; v < 8; v++) begin
                total++;
                if (q_max1[v] != mx[v] || q_idx1[v] != ix[v] || q_idx1[v] > 15) begin
                    bad++;
                    $display("FAIL nc1_result vec%0d: max=%0d idx=%0d, required %0d/%0d",
                             v, q_max1[v], q_idx1[v], mx[v], ix[v]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_ties_and_sign();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_vector();
        test_single_chunk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
